// File: rtl/risc16_seq_alu.sv
// Registered, handshaked RiSC-16 ALU with iterative shift-add MUL.
// Define RISC16_ALU_MULH_EN to expose the MUL high word on result_hi.
module risc16_seq_alu #(
    parameter int WORD_LENGTH = 16,
    parameter int FUNCT_LEN   = 3,
    parameter int CNT_LEN     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] src1,
    input  logic [WORD_LENGTH-1:0] src2,
    input  logic [FUNCT_LEN-1:0]   funct,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] result,
    output logic [WORD_LENGTH-1:0] result_hi,
    output logic                   state,
    output logic                   busy
);

    localparam int W = WORD_LENGTH;
    localparam logic [FUNCT_LEN-1:0] F_ADD  = FUNCT_LEN'(0);
    localparam logic [FUNCT_LEN-1:0] F_NAND = FUNCT_LEN'(1);
    localparam logic [FUNCT_LEN-1:0] F_PAS1 = FUNCT_LEN'(2);
    localparam logic [FUNCT_LEN-1:0] F_PAS2 = FUNCT_LEN'(3);
    localparam logic [FUNCT_LEN-1:0] F_EQ   = FUNCT_LEN'(4);
    localparam logic [FUNCT_LEN-1:0] F_MUL  = FUNCT_LEN'(5);
    localparam logic [FUNCT_LEN-1:0] F_SHL1 = FUNCT_LEN'(6);
`ifdef RISC16_ALU_MULH_EN
    localparam int ACC_W = 2 * W;
`else
    localparam int ACC_W = W + 1;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
    fsm_t fsm_q, fsm_d;

    logic [W-1:0]       mcand_q, mplier_q, mplier_step, prod_lo, result_q;
    logic [ACC_W-1:0]   acc_q, acc_step;
    logic [CNT_LEN-1:0] cnt_q;
    logic [W-1:0]       op_res;
    logic               op_flag, flag_q, last;
    logic [W:0]         psum;

    assign last   = (cnt_q == CNT_LEN'(W - 1));
    assign result = result_q;
    assign state  = flag_q;

    always_comb begin
        op_res  = '0;
        op_flag = 1'b0;
        case (funct)
            F_ADD:   {op_flag, op_res} = {1'b0, src1} + {1'b0, src2};
            F_NAND:  op_res = ~(src1 & src2);
            F_PAS1:  op_res = src1;
            F_PAS2:  op_res = src2;
            F_EQ:    op_flag = (src1 == src2);
            F_SHL1: begin
                op_res  = {src1[W-2:0], 1'b0};
                op_flag = src1[W-1];
            end
            default: ;
        endcase
    end

`ifdef RISC16_ALU_MULH_EN
    logic [W-1:0] hi_q, prod_hi;
    assign result_hi = hi_q;

    always_comb begin
        psum        = {1'b0, acc_q[ACC_W-1:W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step    = {psum, acc_q[W-1:1]};
        mplier_step = mplier_q >> 1;
        prod_lo     = acc_step[W-1:0];
        prod_hi     = acc_step[ACC_W-1:W];
    end
`else
    assign result_hi = '0;

    // Narrow accumulator holds only the running high part; product low bits
    // shift into the vacated top of the multiplier register.
    always_comb begin
        psum        = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step    = {1'b0, psum[W:1]};
        mplier_step = {psum[0], mplier_q[W-1:1]};
        prod_lo     = mplier_step;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = (funct == F_MUL) ? BUSY : DONE;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
`ifdef RISC16_ALU_MULH_EN
            hi_q     <= '0;
`endif
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
`ifdef RISC16_ALU_MULH_EN
                    hi_q <= '0;
`endif
                    if (funct == F_MUL) begin
                        mcand_q  <= src1;
                        mplier_q <= src2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        flag_q   <= 1'b0;
                    end else begin
                        result_q <= op_res;
                        flag_q   <= op_flag;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_step;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        result_q <= prod_lo;
`ifdef RISC16_ALU_MULH_EN
                        hi_q     <= prod_hi;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_seq_alu.sv
// Directed self-checking bench for risc16_seq_alu (W=16), honours RISC16_ALU_MULH_EN.
module tb_risc16_seq_alu;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic        in_ready, out_valid, state, busy;
    logic [15:0] src1, src2, result, result_hi;
    logic [2:0]  funct;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_checks = 0;
    int          lat;

    always #5 clk = ~clk;

    risc16_seq_alu #(.WORD_LENGTH(16), .FUNCT_LEN(3), .CNT_LEN(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .funct(funct), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .state(state), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        funct    = f;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; funct = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_hi", 32'(result_hi), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        issue(3'd0, 16'h0066, 16'h00CD);
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_result", 32'(result), 32'h0133);
        chk("add_state", 32'(state), 32'd0);
        tick();
        chk("add_handoff_valid", 32'(out_valid), 32'd0);
        chk("add_handoff_ready", 32'(in_ready), 32'd1);

        issue(3'd0, 16'hFFFF, 16'h0001);
        chk("addc_result", 32'(result), 32'h0000);
        chk("addc_state", 32'(state), 32'd1);
        tick();
        issue(3'd4, 16'h1234, 16'h1234);
        chk("eq_result", 32'(result), 32'd0);
        chk("eq_state", 32'(state), 32'd1);
        tick();
        issue(3'd4, 16'h1234, 16'h1235);
        chk("neq_state", 32'(state), 32'd0);
        tick();
        issue(3'd2, 16'hA5A5, 16'h0000);
        chk("pass1_result", 32'(result), 32'hA5A5);
        tick();

        issue(3'd5, 16'h0003, 16'h0005);
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_in_ready", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("mul_latency", 32'(lat), 32'd17);
        chk("mul_result", 32'(result), 32'h000F);
        chk("mul_state", 32'(state), 32'd0);
        tick();

        issue(3'd5, 16'hFFFF, 16'hFFFF);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("mulff_latency", 32'(lat), 32'd17);
        chk("mulff_result", 32'(result), 32'h0001);
`ifdef RISC16_ALU_MULH_EN
        chk("mulff_hi", 32'(result_hi), 32'hFFFE);
`else
        chk("mulff_hi", 32'(result_hi), 32'h0000);
`endif
        tick();

        out_ready = 1'b0;
        issue(3'd1, 16'hF0F0, 16'hFF00);
        chk("nand_hi_cleared", 32'(result_hi), 32'h0000);
        funct = 3'd0; src1 = 16'h1111; src2 = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'h0FFF);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_result", 32'(result), 32'h0FFF);

        issue(3'd5, 16'h1234, 16'h5678);
        for (int i = 0; i < 7; i++) tick();
        chk("mid_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        issue(3'd3, 16'h0000, 16'hBEEF);
        chk("pass2_result", 32'(result), 32'hBEEF);
        tick();

        issue(3'd6, 16'h8001, 16'h0000);
        chk("shl1_result", 32'(result), 32'h0002);
        chk("shl1_state", 32'(state), 32'd1);
        tick();
        issue(3'd7, 16'h1234, 16'h5678);
        chk("rsvd_out_valid", 32'(out_valid), 32'd1);
        chk("rsvd_result", 32'(result), 32'd0);
        chk("rsvd_state", 32'(state), 32'd0);
        tick();
        chk("rsvd_handoff", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
